// File: rtl/cv32e40p_obi_instr_arbiter.sv
// Two-master OBI instruction-port arbiter with in-order response routing.
// Holds a stalled choice until granted and returns each response to its issuer.
module cv32e40p_obi_instr_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ARB_MODE        = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ?
                                 $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

    state_e                     state_q;
    state_e                     state_d;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_d;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic                       rr_q;
    logic                       sel;
    logic                       req_raw;
    logic                       eligible;
    logic                       grant;
    logic                       pop;
    logic                       head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Master selection, slave request and lock-until-granted transitions
    always_comb begin
        eligible = count_q < CW'(MAX_OUTSTANDING);
        sel      = 1'b0;
        req_raw  = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            ARB: begin
                if (ARB_MODE == 0) begin
                    sel = (m0_req_i && m1_req_i) ? rr_q : m1_req_i;
                end else begin
                    sel = ~m0_req_i;
                end
                req_raw = eligible & (sel ? m1_req_i : m0_req_i);
                if (req_raw && !s_gnt_i) begin
                    state_d = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                sel     = 1'b0;
                req_raw = 1'b1;
                if (s_gnt_i) state_d = ARB;
            end
            LOCK1: begin
                sel     = 1'b1;
                req_raw = 1'b1;
                if (s_gnt_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // Nothing is requested or granted while reset is held
    assign s_req_o  = req_raw & rst_n;
    assign s_addr_o = sel ? m1_addr_i : m0_addr_i;
    assign grant    = s_req_o & s_gnt_i;
    assign m0_gnt_o = grant & ~sel;
    assign m1_gnt_o = grant & sel;

    assign head        = fifo_q[rd_ptr_q];
    assign pop         = s_rvalid_i & (count_q != '0);
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_err_o    = m0_rvalid_o & s_err_i;
    assign m1_err_o    = m1_rvalid_o & s_err_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign busy_o      = (count_q != '0) | m0_req_i | m1_req_i;
    assign count_d     = count_q + CW'(grant) - CW'(pop);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB;
        else        state_q <= state_d;
    end

    // Outstanding-ID FIFO and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (grant) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= nxt(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= nxt(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // Round-robin pointer favours the master not granted last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rr_q <= 1'b0;
        else if (grant && ARB_MODE == 0) rr_q <= ~sel;
    end

    // Sticky flag for a response with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          protocol_err_o <= 1'b0;
        else if (s_rvalid_i && count_q == '0) protocol_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_cv32e40p_obi_instr_arbiter.sv
// Directed bench for the OBI instruction arbiter.
// Round-robin instance plus a fixed-priority instance sharing stimulus.
module tb_cv32e40p_obi_instr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr;
    logic        s_req, busy, perr;

    logic        f_m0_gnt, f_m0_rvalid, f_m0_err;
    logic        f_m1_gnt, f_m1_rvalid, f_m1_err;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr;
    logic        f_s_req, f_busy, f_perr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_instr_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .busy_o(busy), .protocol_err_o(perr)
    );

    cv32e40p_obi_instr_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(f_m0_gnt),
        .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata),
        .m0_err_o(f_m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(f_m1_gnt),
        .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata),
        .m1_err_o(f_m1_err),
        .s_req_o(f_s_req), .s_addr_o(f_s_addr), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .busy_o(f_busy), .protocol_err_o(f_perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic a0, input logic a1, input logic g,
                       input logic rv, input logic er,
                       input logic [31:0] rd);
        @(negedge clk);
        m0_req   = a0;
        m1_req   = a1;
        s_gnt    = g;
        s_rvalid = rv;
        s_err    = er;
        s_rdata  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_err = 0;
        #1;
        chk("rst_perr", perr, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 0;
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_err = 0;
        m0_addr = 32'h1000; m1_addr = 32'h2000; s_rdata = 0;
        @(negedge clk); #1;
        chk("rst_sreq", s_req, 0);
        chk("rst_gnt", {m0_gnt, m1_gnt, f_m0_gnt, f_m1_gnt}, 0);
        chk("rst_rv", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr0", {perr, f_perr}, 0);
        @(negedge clk);
        rst_n = 1;

        // 1: round-robin alternation, responses routed in order
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t1_c1_g", {m0_gnt, m1_gnt}, 2'b10);
        chk("t1_c1_addr", s_addr, 32'h1000);
        drv(1, 1, 1, 1, 0, 32'hD0);
        chk("t1_c2_g", {m0_gnt, m1_gnt}, 2'b01);
        chk("t1_c2_addr", s_addr, 32'h2000);
        chk("t1_c2_rv", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("t1_c2_rd", m0_rdata, 32'hD0);
        drv(1, 1, 1, 1, 0, 32'hD1);
        chk("t1_c3_g", {m0_gnt, m1_gnt}, 2'b10);
        chk("t1_c3_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        chk("t1_c3_rd", m1_rdata, 32'hD1);
        drv(1, 1, 1, 1, 0, 32'hD2);
        chk("t1_c4_g", {m0_gnt, m1_gnt}, 2'b01);
        chk("t1_c4_rv", {m0_rvalid, m1_rvalid}, 2'b10);
        drv(0, 0, 0, 1, 1, 32'hD3);
        chk("t1_c5_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        chk("t1_c5_err", {m0_err, m1_err}, 2'b01);
        drv(0, 0, 0, 0, 0, 32'h0);
        chk("t1_idle_busy", busy, 0);

        // 2: stalled M1 request stays locked ahead of M0
        m1_addr = 32'h3000; m0_addr = 32'h4000;
        drv(0, 1, 0, 0, 0, 32'h0);
        chk("t2_c1_sreq", s_req, 1);
        chk("t2_c1_addr", s_addr, 32'h3000);
        drv(1, 1, 0, 0, 0, 32'h0);
        chk("t2_c2_addr", s_addr, 32'h3000);
        chk("t2_c2_g", {m0_gnt, m1_gnt}, 2'b00);
        drv(1, 1, 0, 0, 0, 32'h0);
        chk("t2_c3_addr", s_addr, 32'h3000);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t2_c4_g", {m0_gnt, m1_gnt}, 2'b01);
        chk("t2_c4_addr", s_addr, 32'h3000);
        drv(1, 0, 1, 1, 0, 32'hE0);
        chk("t2_c5_g", {m0_gnt, m1_gnt}, 2'b10);
        chk("t2_c5_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        drv(0, 0, 0, 1, 0, 32'hE1);
        chk("t2_c6_rv", {m0_rvalid, m1_rvalid}, 2'b10);

        // 3: full blocks requests; push+pop keeps order
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t3_c1_g", {m0_gnt, m1_gnt}, 2'b01);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t3_c2_g", {m0_gnt, m1_gnt}, 2'b10);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t3_full_sreq", s_req, 0);
        chk("t3_full_busy", busy, 1);
        drv(1, 1, 1, 1, 0, 32'h0);
        chk("t3_c4_sreq", s_req, 0);
        chk("t3_c4_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        drv(1, 1, 1, 1, 0, 32'h0);
        chk("t3_c5_g", {m0_gnt, m1_gnt}, 2'b01);
        chk("t3_c5_rv", {m0_rvalid, m1_rvalid}, 2'b10);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t3_c6_g", {m0_gnt, m1_gnt}, 2'b10);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t3_c7_sreq", s_req, 0);
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("t3_c8_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("t3_c9_rv", {m0_rvalid, m1_rvalid}, 2'b10);

        // 4: response with nothing outstanding
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("t4_rv", {m0_rvalid, m1_rvalid}, 2'b00);
        chk("t4_perr_pre", perr, 0);
        drv(0, 0, 0, 0, 0, 32'h0);
        chk("t4_perr", perr, 1);
        drv(0, 0, 0, 0, 0, 32'h0);
        chk("t4_perr_sticky", perr, 1);
        do_reset();

        // 6: reset with two outstanding, then a late response
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t6_g1", {m0_gnt, m1_gnt}, 2'b10);
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t6_g2", {m0_gnt, m1_gnt}, 2'b01);
        @(negedge clk);
        rst_n = 0; s_rvalid = 1;
        #1;
        chk("t6_rst_g", {m0_gnt, m1_gnt, s_req}, 0);
        chk("t6_rst_rv", {m0_rvalid, m1_rvalid}, 0);
        @(negedge clk);
        rst_n = 1;
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("t6_late_rv", {m0_rvalid, m1_rvalid}, 0);
        drv(0, 0, 0, 0, 0, 32'h0);
        chk("t6_late_perr", perr, 1);
        chk("t6_busy", busy, 0);
        do_reset();

        // 5: fixed priority favours M0 until it drops
        m0_addr = 32'h5000; m1_addr = 32'h6000;
        drv(1, 1, 1, 0, 0, 32'h0);
        chk("t5_g1", {f_m0_gnt, f_m1_gnt}, 2'b10);
        chk("t5_addr", f_s_addr, 32'h5000);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 1, 1, 0, 32'h0);
            chk("t5_gn", {f_m0_gnt, f_m1_gnt}, 2'b10);
            chk("t5_rvn", {f_m0_rvalid, f_m1_rvalid}, 2'b10);
        end
        drv(0, 1, 1, 1, 0, 32'h0);
        chk("t5_m1_g", {f_m0_gnt, f_m1_gnt}, 2'b01);
        chk("t5_m1_addr", f_s_addr, 32'h6000);
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("t5_m1_rv", {f_m0_rvalid, f_m1_rvalid}, 2'b01);
        chk("t5_perr", {perr, f_perr}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
